// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the TX arbiter: port count, port index type and FSM states.
package tx_arbiter_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Round-robin priority picker: first set mask bit at or after the pointer, wrapping 3->0.
module rr_picker
    import tx_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] mask_i,
    input  port_idx_t            ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output port_idx_t            idx_o,
    output logic                 any_o
);

    port_idx_t k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = ptr_i + port_idx_t'(i);
            if (!any_o && mask_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Per-TX-port frame arbiter: round-robin grant over RX queues, inter-frame gap.
// Optional stall watchdog enabled by defining TX_ARBITER_TIMEOUT_EN.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int P_PORT_ID    = 0,
    parameter int P_GAP_CYCLES = 1,
    parameter int P_TIMEOUT    = 255
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [3:0] req_i,
    input  logic [3:0] valid_i,
    input  logic [3:0] last_i,
    output logic [3:0] grant_o,
    output logic [1:0] sel_o,
    output logic       tx_ctrl_o,
    output logic       busy_o,
    output logic       timeout_o
);

    state_e     state_q;
    logic [3:0] grant_q;
    port_idx_t  sel_q;
    port_idx_t  ptr_q;
    logic [3:0] gap_cnt_q;

    logic [3:0] req_mask;
    logic [3:0] pick_gnt;
    port_idx_t  pick_idx;
    logic       pick_any;
    logic       in_xfer;
    logic       byte_vld;
    logic       byte_last;
    logic       wdog_fire;
    logic       frame_end;

    // A port never forwards its own RX queue back out.
    assign req_mask = req_i & ~(4'b0001 << P_PORT_ID);

    rr_picker u_picker (
        .mask_i  (req_mask),
        .ptr_i   (ptr_q),
        .grant_o (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign in_xfer   = (state_q == ST_XFER);
    assign byte_vld  = in_xfer & valid_i[sel_q];
    assign byte_last = byte_vld & last_i[sel_q];
    assign frame_end = byte_last | wdog_fire;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= port_idx_t'(P_PORT_ID + 1);
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_gnt;
                        sel_q   <= pick_idx;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (frame_end) begin
                        grant_q <= '0;
                        ptr_q   <= sel_q + 2'd1;
                        if (P_GAP_CYCLES > 0) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= 4'(P_GAP_CYCLES - 1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TX_ARBITER_TIMEOUT_EN
    localparam int WD_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT + 1) : 1;

    logic [WD_W-1:0] stall_cnt_q;
    logic            timeout_q;

    // Counts consecutive stalled XFER cycles; any byte from the owner restarts it.
    assign wdog_fire = in_xfer & ~valid_i[sel_q] & (stall_cnt_q == WD_W'(P_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= wdog_fire;
            if (!in_xfer || byte_vld || wdog_fire) begin
                stall_cnt_q <= '0;
            end else begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^(32'(P_TIMEOUT));
    assign wdog_fire          = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign tx_ctrl_o = byte_vld;
    assign busy_o    = in_xfer;

endmodule
